spi_frame_controller: RTL and testbench

//  Frame-level sequencer between spi_peripheral's byte interface and a 32-bit register/parameter bank.

---
 rtl/spi_frame_pkg.sv | 21 ++
 rtl/spi_frame_controller_if.sv | 36 +++
 rtl/spi_word_shifter.sv | 37 +++
 rtl/spi_frame_controller.sv | 215 +++++++++++++++++++++
 tb/tb_spi_frame_controller.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI frame controller.
// Optional feature macro: SPI_FRAME_CHECKSUM_EN (adds the CSUM state).
package spi_frame_pkg;

   // Header bit selecting write (1) or read (0).
   localparam int HDR_RW_BIT = 7;

   // Byte presented to the SPI shifter whenever no read data is pending.
   localparam logic [7:0] TX_IDLE_BYTE = 8'h00;

`ifdef SPI_FRAME_CHECKSUM_EN
   typedef enum logic [3:0] {
      IDLE, HDR, WDATA, COMMIT, RFETCH, RLOAD, RDATA, DONE, CSUM
   } state_t;
`else
   typedef enum logic [3:0] {
      IDLE, HDR, WDATA, COMMIT, RFETCH, RLOAD, RDATA, DONE
   } state_t;
`endif

endpackage

// File: rtl/spi_frame_controller_if.sv
// Byte-side and register-bank-side signals of the SPI frame controller.
//
// Handshake semantics: there is no back-pressure anywhere. rx_valid is a
// 1-cycle pulse and rx_byte is only meaningful while it is high. wr_en and
// rd_en are 1-cycle strobes; wr_addr/wr_data/rd_addr are valid with them.
// rd_data must be valid exactly one cycle after rd_en. frame_err is a 1-cycle
// pulse. ss is active low and already synchronised to clk.
interface spi_frame_controller_if #(
   parameter int ADDR_W     = 7,
   parameter int WORD_BYTES = 4
);
   logic                    ss;
   logic                    rx_valid;
   logic [7:0]              rx_byte;
   logic [7:0]              tx_byte;
   logic                    wr_en;
   logic [ADDR_W-1:0]       wr_addr;
   logic [8*WORD_BYTES-1:0] wr_data;
   logic                    rd_en;
   logic [ADDR_W-1:0]       rd_addr;
   logic [8*WORD_BYTES-1:0] rd_data;
   logic                    busy;
   logic                    frame_err;

   // Controller side.
   modport slave (
      input  ss, rx_valid, rx_byte, rd_data,
      output tx_byte, wr_en, wr_addr, wr_data, rd_en, rd_addr, busy, frame_err
   );

   // Host / register-bank side.
   modport master (
      output ss, rx_valid, rx_byte, rd_data,
      input  tx_byte, wr_en, wr_addr, wr_data, rd_en, rd_addr, busy, frame_err
   );
endinterface

// File: rtl/spi_word_shifter.sv
// Word register for the frame controller: parallel load (read word),
// byte shift-in from the bottom (write data) and byte shift-out toward the
// top with zero fill (read streaming). o_next_byte is the byte that becomes
// the MSB after the next shift-out.
module spi_word_shifter #(
   parameter int WORD_BYTES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_load,
   input  logic [8*WORD_BYTES-1:0] i_load_word,
   input  logic                    i_shift_in,
   input  logic [7:0]              i_in_byte,
   input  logic                    i_shift_out,
   output logic [8*WORD_BYTES-1:0] o_word,
   output logic [7:0]              o_next_byte
);
   localparam int W = 8 * WORD_BYTES;

   logic [W-1:0] r_word;

   // Load has priority; the controller never asserts two controls at once.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_word <= '0;
      end else if (i_load) begin
         r_word <= i_load_word;
      end else if (i_shift_in) begin
         r_word <= {r_word[W-9:0], i_in_byte};
      end else if (i_shift_out) begin
         r_word <= {r_word[W-9:0], 8'h00};
      end
   end

   assign o_word      = r_word;
   assign o_next_byte = r_word[W-9 -: 8];
endmodule

// File: rtl/spi_frame_controller.sv
// Frame sequencer between an SPI byte interface and a 32-bit register bank.
// Header byte: bit7 = write, low ADDR_W bits = address. Write frames collect
// WORD_BYTES data bytes MSB-first and issue one wr_en; read frames issue one
// rd_en and stream the word back MSB-first on tx_byte. Releasing ss before the
// frame completes aborts it with a frame_err pulse.
// Optional feature macro: SPI_FRAME_CHECKSUM_EN (XOR checksum byte on both
// write and read frames).
module spi_frame_controller
   import spi_frame_pkg::*;
#(
   parameter int ADDR_W     = 7,
   parameter int WORD_BYTES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   spi_frame_controller_if.slave  bus,
   output state_t                 o_dbg_state
);
   localparam int W     = 8 * WORD_BYTES;
   localparam int CNT_W = $clog2(WORD_BYTES + 1);

`ifdef SPI_FRAME_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   // Index of the last write data byte, and of the last read slot (the
   // checksum slot follows the data when enabled).
   localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WORD_BYTES - 1);
   localparam logic [CNT_W-1:0] R_LAST = CSUM_EN ? CNT_W'(WORD_BYTES) : W_LAST;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_csum;
   logic [7:0]        r_tx_byte;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [W-1:0]      r_wr_data;
   logic              r_rd_en;
   logic [ADDR_W-1:0] r_rd_addr;
   logic              r_frame_err;

   logic              w_load;
   logic              w_shift_in;
   logic              w_shift_out;
   logic [W-1:0]      w_word;
   logic [7:0]        w_next_byte;

   function automatic logic [7:0] xor_bytes(input logic [W-1:0] word);
      logic [7:0] acc;
      acc = '0;
      for (int i = 0; i < WORD_BYTES; i++) acc = acc ^ word[8*i +: 8];
      return acc;
   endfunction

   // Shift controls; shifting during an abort is harmless because every new
   // write frame overwrites the whole word and reads reload it.
   assign w_load      = (r_state == RLOAD);
   assign w_shift_in  = (r_state == WDATA) && bus.rx_valid;
   assign w_shift_out = (r_state == RDATA) && bus.rx_valid;

   spi_word_shifter #(.WORD_BYTES(WORD_BYTES)) u_shifter (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_load),
      .i_load_word (bus.rd_data),
      .i_shift_in  (w_shift_in),
      .i_in_byte   (bus.rx_byte),
      .i_shift_out (w_shift_out),
      .o_word      (w_word),
      .o_next_byte (w_next_byte)
   );

   // Frame FSM with registered strobes, tx byte and error pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_addr      <= '0;
         r_csum      <= '0;
         r_tx_byte   <= TX_IDLE_BYTE;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_rd_en     <= 1'b0;
         r_rd_addr   <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_wr_en     <= 1'b0;
         r_rd_en     <= 1'b0;
         r_frame_err <= 1'b0;
         case (r_state)
            IDLE: begin
               r_tx_byte <= TX_IDLE_BYTE;
               r_cnt     <= '0;
               if (!bus.ss) r_state <= HDR;
            end
            HDR: begin
               if (bus.ss) begin
                  r_frame_err <= 1'b1;
                  r_state     <= IDLE;
               end else if (bus.rx_valid) begin
                  r_addr <= bus.rx_byte[ADDR_W-1:0];
                  r_csum <= bus.rx_byte;
                  r_cnt  <= '0;
                  if (bus.rx_byte[HDR_RW_BIT]) begin
                     r_state <= WDATA;
                  end else begin
                     r_rd_en   <= 1'b1;
                     r_rd_addr <= bus.rx_byte[ADDR_W-1:0];
                     r_state   <= RFETCH;
                  end
               end
            end
            WDATA: begin
               // ss may rise together with the final byte; that byte still counts.
               if (bus.ss && !(bus.rx_valid && r_cnt == W_LAST && !CSUM_EN)) begin
                  r_frame_err <= 1'b1;
                  r_state     <= IDLE;
               end else if (bus.rx_valid) begin
                  r_csum <= r_csum ^ bus.rx_byte;
                  if (r_cnt == W_LAST) begin
`ifdef SPI_FRAME_CHECKSUM_EN
                     r_state <= CSUM;
`else
                     r_wr_en   <= 1'b1;
                     r_wr_addr <= r_addr;
                     r_wr_data <= {w_word[W-9:0], bus.rx_byte};
                     r_state   <= COMMIT;
`endif
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
`ifdef SPI_FRAME_CHECKSUM_EN
            CSUM: begin
               if (bus.ss && !bus.rx_valid) begin
                  r_frame_err <= 1'b1;
                  r_state     <= IDLE;
               end else if (bus.rx_valid) begin
                  if (bus.rx_byte == r_csum) begin
                     r_wr_en   <= 1'b1;
                     r_wr_addr <= r_addr;
                     r_wr_data <= w_word;
                     r_state   <= COMMIT;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= DONE;
                  end
               end
            end
`endif
            COMMIT: begin
               r_state <= DONE;
            end
            RFETCH: begin
               if (bus.ss) begin
                  r_frame_err <= 1'b1;
                  r_state     <= IDLE;
               end else begin
                  r_state <= RLOAD;
               end
            end
            RLOAD: begin
               if (bus.ss) begin
                  r_frame_err <= 1'b1;
                  r_tx_byte   <= TX_IDLE_BYTE;
                  r_state     <= IDLE;
               end else begin
                  r_tx_byte <= bus.rd_data[W-1 -: 8];
                  r_csum    <= r_csum ^ xor_bytes(bus.rd_data);
                  r_cnt     <= '0;
                  r_state   <= RDATA;
               end
            end
            RDATA: begin
               if (bus.ss && !(bus.rx_valid && r_cnt == R_LAST)) begin
                  r_frame_err <= 1'b1;
                  r_tx_byte   <= TX_IDLE_BYTE;
                  r_state     <= IDLE;
               end else if (bus.rx_valid) begin
                  if (r_cnt == R_LAST) begin
                     r_tx_byte <= TX_IDLE_BYTE;
                     r_state   <= DONE;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                     if (CSUM_EN && r_cnt == W_LAST) r_tx_byte <= r_csum;
                     else                            r_tx_byte <= w_next_byte;
                  end
               end
            end
            DONE: begin
               r_tx_byte <= TX_IDLE_BYTE;
               if (bus.ss) r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.tx_byte   = r_tx_byte;
   assign bus.wr_en     = r_wr_en;
   assign bus.wr_addr   = r_wr_addr;
   assign bus.wr_data   = r_wr_data;
   assign bus.rd_en     = r_rd_en;
   assign bus.rd_addr   = r_rd_addr;
   assign bus.busy      = (r_state != IDLE);
   assign bus.frame_err = r_frame_err;
   assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_spi_frame_controller.sv
// Self-checking bench for spi_frame_controller: directed frames plus
// randomized read/write/abort frames against a byte-level reference model.
module tb_spi_frame_controller;
   import spi_frame_pkg::*;

   localparam int ADDR_W = 7;
   localparam int WB     = 4;
   localparam int W      = 8 * WB;
`ifdef SPI_FRAME_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   state_t dbg_state;

   int total   = 0;
   int bad     = 0;
   int wr_cnt  = 0;
   int rd_cnt  = 0;
   int err_cnt = 0;

   logic [ADDR_W-1:0]   exp_rd_addr = '0;
   logic [W-1:0]        mem [128];
   logic [ADDR_W+W-1:0] exp_q[$];

   spi_frame_controller_if #(.ADDR_W(ADDR_W), .WORD_BYTES(WB)) bus ();

   spi_frame_controller #(.ADDR_W(ADDR_W), .WORD_BYTES(WB)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // ---------------- monitor / register bank model ----------------
   always @(negedge clk) begin
      logic [ADDR_W+W-1:0] e;
      if (bus.wr_en) begin
         wr_cnt++;
         check("wr_has_exp", 64'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wr_addr", 64'(bus.wr_addr), 64'(e[ADDR_W+W-1:W]));
            check("wr_data", 64'(bus.wr_data), 64'(e[W-1:0]));
         end
      end
      if (bus.rd_en) begin
         rd_cnt++;
         check("rd_addr", 64'(bus.rd_addr), 64'(exp_rd_addr));
         bus.rd_data = mem[bus.rd_addr];
      end
      if (bus.frame_err) err_cnt++;
   end

   // ---------------- driver tasks ----------------
   task automatic send_byte(input logic [7:0] b, input bit release_ss);
      repeat ($urandom_range(2, 4)) @(posedge clk);
      #1;
      bus.rx_valid = 1'b1;
      bus.rx_byte  = b;
      if (release_ss) bus.ss = 1'b1;
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic frame_start();
      @(posedge clk);
      #1 bus.ss = 1'b0;
   endtask

   task automatic frame_end();
      bit was_low;
      was_low = !bus.ss;
      @(posedge clk);
      #1 bus.ss = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (was_low) check("busy_after_ss", 64'(bus.busy), 0);
      repeat (3) @(posedge clk);
   endtask

   // Write frame: nsend data bytes (< WB aborts), optional wrong checksum,
   // optional ss release with the final byte, optional extra byte after it.
   task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [W-1:0] data,
                           input int nsend, input bit bad_cs, input bit coincide,
                           input bit extra);
      logic [7:0] hdr, b, cs;
      int         wr0, er0;
      bit         good;
      wr0 = wr_cnt;
      er0 = err_cnt;
      hdr = {1'b1, addr};
      cs  = hdr;
      frame_start();
      send_byte(hdr, 1'b0);
      for (int i = 0; i < nsend; i++) begin
         b  = 8'((data >> (8 * (WB - 1 - i))) & 32'hFF);
         cs = cs ^ b;
         send_byte(b, coincide && (i == WB - 1) && !CSUM);
      end
      good = (nsend == WB);
      if (CSUM && good) begin
         send_byte(bad_cs ? ((cs == 8'h00) ? 8'hFF : 8'h00) : cs, coincide);
         good = !bad_cs;
      end
      if (good) exp_q.push_back({addr, data});
      if (extra) send_byte(8'($urandom), 1'b0);
      frame_end();
      check("wr_count", 64'(wr_cnt - wr0), 64'(good));
      check("err_count_wr", 64'(err_cnt - er0), 64'(!good));
   endtask

   // Read frame: nslots dummy bytes from the host; fewer than a full frame aborts.
   task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [W-1:0] word,
                          input int nslots);
      logic [7:0] hdr, cs;
      logic [7:0] exp_tx [WB+2];
      int         rd0, er0, full;
      rd0         = rd_cnt;
      er0         = err_cnt;
      mem[addr]   = word;
      exp_rd_addr = addr;
      hdr         = {1'b0, addr};
      full        = WB + int'(CSUM);
      cs          = hdr;
      for (int i = 0; i < WB + 2; i++) exp_tx[i] = 8'h00;
      for (int i = 0; i < WB; i++) begin
         exp_tx[i] = 8'((word >> (8 * (WB - 1 - i))) & 32'hFF);
         cs        = cs ^ exp_tx[i];
      end
      if (CSUM) exp_tx[WB] = cs;
      frame_start();
      send_byte(hdr, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("tx_first", 64'(bus.tx_byte), 64'(exp_tx[0]));
      for (int i = 0; i < nslots; i++) begin
         send_byte(8'($urandom), 1'b0);
         @(negedge clk);
         check("tx_slot", 64'(bus.tx_byte), 64'(exp_tx[i+1]));
      end
      frame_end();
      check("rd_count", 64'(rd_cnt - rd0), 1);
      check("err_count_rd", 64'(err_cnt - er0), 64'(nslots < full));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx"},     64'(bus.tx_byte), 0);
      check({tag, "_wr_en"},  64'(bus.wr_en), 0);
      check({tag, "_rd_en"},  64'(bus.rd_en), 0);
      check({tag, "_waddr"},  64'(bus.wr_addr), 0);
      check({tag, "_wdata"},  64'(bus.wr_data), 0);
      check({tag, "_raddr"},  64'(bus.rd_addr), 0);
      check({tag, "_busy"},   64'(bus.busy), 0);
      check({tag, "_ferr"},   64'(bus.frame_err), 0);
      check({tag, "_state"},  64'(dbg_state), 64'(IDLE));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int wr0, er0, n;
      bus.ss       = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_byte  = 8'h00;
      bus.rd_data  = '0;
      for (int i = 0; i < 128; i++) mem[i] = '0;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst");
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);

      // Basic write and read.
      do_write(7'h05, 32'hDEADBEEF, WB, 1'b0, 1'b0, 1'b0);
      do_read(7'h05, 32'h12345678, WB + int'(CSUM));

      // Aborted write after two data bytes.
      do_write(7'h01, 32'hCAFE0000, 2, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of a write frame.
      wr0 = wr_cnt;
      er0 = err_cnt;
      frame_start();
      send_byte(8'h85, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      @(posedge clk);
      #1;
      rst    = 1'b1;
      bus.ss = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("midrst");
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      check("midrst_wr", 64'(wr_cnt - wr0), 0);
      check("midrst_err", 64'(err_cnt - er0), 0);
      do_write(7'h2A, 32'h0BADF00D, WB, 1'b0, 1'b0, 1'b0);

      // ss released together with the final byte; extra byte afterwards.
      do_write(7'h33, 32'hA5A55A5A, WB, 1'b0, 1'b1, 1'b1);
      // Extra byte in DONE while ss still low.
      do_write(7'h7F, 32'hFFFFFFFF, WB, 1'b0, 1'b0, 1'b1);
      // Boundary addresses and an aborted read.
      do_write(7'h00, 32'h00000000, WB, 1'b0, 1'b0, 1'b0);
      do_read(7'h7F, 32'h89ABCDEF, 2);

      // Checksum rejection (only meaningful with the checksum feature).
      if (CSUM) begin
         do_write(7'h05, 32'hDEADBEEF, WB, 1'b1, 1'b0, 1'b0);
      end

      // Randomized frames.
      for (int k = 0; k < 24; k++) begin
         if ($urandom_range(0, 1) == 0) begin
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WB - 1)) : WB;
            do_write(7'($urandom), $urandom, n,
                     CSUM && ($urandom_range(0, 4) == 0),
                     $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
         end else begin
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WB - 1)) : WB + int'(CSUM);
            do_read(7'($urandom), $urandom, n);
         end
      end

      repeat (4) @(posedge clk);
      check("scoreboard_empty", 64'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
